add_sched: RTL
==============

ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 SHALL have parameter W, default 8, operand/sum width in bits.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters; IDW = clog2(NREQ), 2 at default.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 SHALL have port req_a  input  NREQ*W  operand A; requester i occupies bits [i*W +: W].
REQ-007 SHALL have port req_b  input  NREQ*W  operand B; same packing as req_a.
REQ-008 SHALL have port req_ready  output  NREQ  one-hot accept strobe; bit i high = requester i's operands taken this cycle.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rsp_sum  output  W  registered sum of the accepted operands, modulo 2^W.
REQ-012 SHALL have port rsp_carry  output  1  carry-out of the W-bit add.
REQ-013 SHALL have port rsp_id  output  IDW  index of the requester that owns rsp_sum.
REQ-014 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 SHALL implement one shared W-bit adder, used by one requester at a time, under the FSM states IDLE, ADD and RESP.
REQ-016 In IDLE with any req_valid high, SHALL grant exactly one requester, capture its req_a/req_b into operand registers, drive its req_ready bit high that same cycle, and go to ADD.
REQ-017 In IDLE with no req_valid, SHALL drive req_ready all-zero and stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NREQ and wraps NREQ-1 -> 0; last_grant updates only on a grant.
REQ-019 In ADD, SHALL register {rsp_carry, rsp_sum} = a + b as a (W+1)-bit zero-extended add, register rsp_id, and go to RESP.
REQ-020 In RESP, SHALL hold rsp_valid high with rsp_sum, rsp_carry and rsp_id stable until the cycle rsp_ready is high, then go to IDLE.
REQ-021 SHALL allow rsp_ready to be high before rsp_valid; rsp_ready in RESP in the first cycle SHALL complete the transfer in that cycle.
REQ-022 Latency SHALL be: grant in cycle N, rsp_valid high in cycle N+2; minimum spacing between grants SHALL be 3 cycles.
REQ-023 req_ready SHALL be zero in ADD and RESP; requesters keep req_valid and operands held until their req_ready is seen.
REQ-024 A requester that holds req_valid continuously SHALL be granted within NREQ grants.
REQ-025 Drops of req_valid by non-granted requesters SHALL have no effect on state.
REQ-026 SHALL drive rsp_valid from a register, never combinationally from inputs.

Reset
REQ-027 While rst is high, SHALL force: state IDLE, rsp_valid 0, rsp_sum 0, rsp_carry 0, rsp_id 0, busy 0, req_ready 0, and last_grant = NREQ-1 so that requester 0 has first priority.
REQ-028 Assertion of rst in ADD or RESP SHALL abort the operation; the result is discarded and never presented.
REQ-029 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge of clk with rst low.

Structure
REQ-030 Package add_sched_pkg SHALL hold the state enum (IDLE, ADD, RESP) and the default constants W=8 and NREQ=4.
REQ-031 Sub-module rr_arbiter (inputs: request vector, last_grant; outputs: one-hot grant, grant index) SHALL contain the round-robin logic; add_sched SHALL contain the FSM, operand registers and adder.

Verification
REQ-032 Single add: rst, then req_valid=0001 with a0=0x12, b0=0x34 -> req_ready=0001 in cycle N, rsp_valid at N+2 with sum=0x46, carry=0, id=0.
REQ-033 Overflow: a1=0xFF, b1=0x01 -> sum=0x00, carry=1, id=1; also a=0xFF, b=0xFF -> sum=0xFE, carry=1.
REQ-034 Fairness: req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0 with grants 3 cycles apart.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_sum/carry/id stable, req_ready=0000, busy=1; rsp_ready=1 -> IDLE next cycle.
REQ-036 Reset in ADD: rst pulse while in ADD -> rsp_valid never asserts, all outputs 0; after release, req_valid=1000 -> req_ready=1000 within 1 cycle.
REQ-037 Wrap-around: last grant to 3, then req_valid=1001 -> grant requester 0, then 3.

Source files
------------

// File: rtl/add_sched_pkg.sv
// Shared types and default sizing for the shared-adder scheduler.
package add_sched_pkg;
  localparam int DEF_W    = 8;
  localparam int DEF_NREQ = 4;

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester found after last_grant, wrapping to 0.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);
  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/add_sched.sv
// Time-shares one W-bit adder among NREQ requesters: grant, add, hold result.
module add_sched
  import add_sched_pkg::*;
#(
  parameter  int W    = DEF_W,
  parameter  int NREQ = DEF_NREQ,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W-1:0]        rsp_sum,
  output logic                rsp_carry,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy
);
  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant, gnt_idx, op_id;
  logic [NREQ-1:0] gnt;
  logic           take;
  logic [W-1:0]   op_a, op_b;
  logic [W:0]     sum_full;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign sum_full = {1'b0, op_a} + {1'b0, op_b};
  assign busy     = (state != IDLE);

  // rst gates the grant so nothing is accepted while reset is still held
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: if (|req_valid && !rst) begin
        take      = 1'b1;
        req_ready = gnt;
        state_nxt = ADD;
      end
      ADD:     state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDW'(NREQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= '0;
    end else begin
      if (take) begin
        op_a       <= req_a[gnt_idx*W +: W];
        op_b       <= req_b[gnt_idx*W +: W];
        op_id      <= gnt_idx;
        last_grant <= gnt_idx;
      end
      if (state == ADD) begin
        {rsp_carry, rsp_sum} <= sum_full;
        rsp_id               <= op_id;
        rsp_valid            <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule
